riscv_instr_fetch_unit: RTL and testbench

Instruction prefetch unit that sits directly upstream of the IF stage. It issues word-aligned requests on the instruction memory port (req/gnt/rvalid), buffers returned words in a small FIFO, and realigns them into 32-bit instruction slots at halfword granularity, handling compressed and word-straddling instructions. It presents one instruction slot per cycle on a valid/ready handshake. On a branch request it flushes and restarts from the new address.

---
 rtl/riscv_instr_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_riscv_instr_fetch_unit.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instr_fetch_unit.sv
// Instruction prefetch unit: word fetch over req/gnt/rvalid,
// word FIFO, halfword realignment into 32-bit instruction slots.
module riscv_instr_fetch_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_pmp_i,
  output logic        fetch_failed_o,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] TWO   = (AW+1)'(2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_ABORTED
  } state_t;

  state_t      state_q, state_d, issue_next;
  logic [31:0] fptr_q, fptr_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_nx;
  logic [AW:0] cnt_q;
  logic        failed_q;

  logic [31:0] target, head;
  logic [15:0] second;
  logic        failed_eff, room, can_issue, granted;
  logic        push, pop, fire, is16, head_c;
  logic        nonempty, two, slot_ok;

  assign target     = {addr_i[31:2], 2'b00};
  assign failed_eff = failed_q & ~branch_i;
  assign room       = branch_i | (cnt_q < DEPTH);
  assign can_issue  = (state_q == IDLE) |
                      ((state_q == WAIT_ABORTED) &
                       instr_rvalid_i);

  assign instr_req_o = (state_q == WAIT_GNT) |
                       (can_issue & req_i &
                        ~failed_eff & room);
  assign instr_addr_o = branch_i ? target : fptr_q;

  assign granted = instr_req_o & instr_gnt_i &
                   ~instr_err_pmp_i;
  assign fptr_d  = granted ? instr_addr_o + 32'd4
                           : instr_addr_o;

  always_comb begin
    issue_next = IDLE;
    if (instr_req_o && !instr_err_pmp_i)
      issue_next = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WAIT_GNT: state_d = issue_next;
      WAIT_RVALID: begin
        if (instr_rvalid_i)
          state_d = IDLE;
        else if (branch_i)
          state_d = WAIT_ABORTED;
      end
      WAIT_ABORTED: begin
        if (instr_rvalid_i)
          state_d = issue_next;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = (state_q == WAIT_RVALID) &
                instr_rvalid_i & ~branch_i;

  // Realignment of the current slot from head/second word
  assign rd_nx    = rd_q + AW'(1);
  assign head     = mem_q[rd_q];
  assign second   = mem_q[rd_nx][15:0];
  assign head_c   = head[17:16] != 2'b11;
  assign nonempty = cnt_q != '0;
  assign two      = cnt_q >= TWO;

  always_comb begin
    slot_ok = 1'b0;
    unique case (1'b1)
      !cur_q[1]:          slot_ok = nonempty;
      cur_q[1] && head_c: slot_ok = nonempty;
      cur_q[1] && !head_c: slot_ok = two;
    endcase
  end

  assign rdata_o = cur_q[1] ? {second, head[31:16]}
                            : head;
  assign addr_o  = cur_q;
  assign valid_o = slot_ok & ~branch_i;

  assign is16 = rdata_o[1:0] != 2'b11;
  assign fire = valid_o & ready_i;
  // A word is done once the slot end crosses its boundary
  assign pop  = fire & (cur_q[1] | ~is16);

  always_comb begin
    cur_d = cur_q;
    if (branch_i)
      cur_d = addr_i;
    else if (fire)
      cur_d = cur_q + (is16 ? 32'd2 : 32'd4);
  end

  assign fetch_failed_o = failed_q;
  assign busy_o = instr_req_o |
                  (state_q == WAIT_RVALID) |
                  (state_q == WAIT_ABORTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fptr_q   <= '0;
      cur_q    <= '0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fptr_q   <= fptr_d;
      cur_q    <= cur_d;
      failed_q <= failed_eff |
                  (instr_req_o & instr_err_pmp_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else if (branch_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= instr_rdata_i;
        wr_q <= wr_q + AW'(1);
      end
      if (pop)
        rd_q <= rd_nx;
      cnt_q <= cnt_q + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_riscv_instr_fetch_unit.sv
// Directed bench for riscv_instr_fetch_unit with a
// single-outstanding memory model of configurable latency.
module tb_riscv_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o;
  logic [31:0] rdata_o, addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_pmp_i;
  logic        fetch_failed_o, busy_o;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem_word [1024];
  int          lat;
  bit          pend;
  int          cnt;
  logic [31:0] paddr;
  int          naccept;

  riscv_instr_fetch_unit #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .branch_i(branch_i),
    .addr_i(addr_i), .ready_i(ready_i),
    .valid_o(valid_o), .rdata_o(rdata_o),
    .addr_o(addr_o), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
    .instr_err_pmp_i(instr_err_pmp_i),
    .fetch_failed_o(fetch_failed_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Memory: accept sampled mid-cycle, rvalid after lat cycles
  initial begin
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    pend = 0; cnt = 0; paddr = '0;
    naccept = 0;
    forever begin
      @(negedge clk);
      if (!pend && rst_n && instr_req_o &&
          instr_gnt_i && !instr_err_pmp_i) begin
        pend = 1;
        cnt = lat;
        paddr = instr_addr_o;
        naccept++;
      end
      @(posedge clk); #1;
      instr_rvalid_i = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          instr_rvalid_i = 1'b1;
          instr_rdata_i = mem_word[paddr[11:2]];
          pend = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = 1'b0; branch_i = 1'b0;
    addr_i = '0; ready_i = 1'b0;
    instr_gnt_i = 1'b1;
    instr_err_pmp_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 1024; i++)
      mem_word[i] = 32'h0000_0013;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget,
                            output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({valid_o, instr_req_o, busy_o,
         fetch_failed_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 0000",
        {valid_o, instr_req_o, busy_o,
         fetch_failed_o});
    end
    n_cmp++;
    if (addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_addr_o: got %h want 0", addr_o);
    end
    n_cmp++;
    if (instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_instr_addr: got %h want 0",
        instr_addr_o);
    end
    n_cmp++;
    if (rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h want 0", rdata_o);
    end
    step();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({instr_req_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_idle: req/busy %b want 00",
        {instr_req_o, busy_o});
    end
  endtask

  task automatic test_branch_aligned();
    logic [31:0] held;
    do_reset();
    mem_word[10'h020] = 32'h00A0_0093;
    step();
    req_i = 1'b1;
    branch_i = 1'b1;
    addr_i = 32'h1C00_0080;
    @(negedge clk);
    n_cmp++;
    if (instr_req_o !== 1'b1 ||
        instr_addr_o !== 32'h1C00_0080) begin
      n_fail++;
      $display("FAIL br_req: req %b addr %h want 1 1c000080",
        instr_req_o, instr_addr_o);
    end
    step();
    branch_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL br_c1: valid %b busy %b want 0 1",
        valid_o, busy_o);
    end
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b1 || addr_o !== 32'h1C00_0080 ||
        rdata_o !== 32'h00A0_0093) begin
      n_fail++;
      $display("FAIL br_c2: v %b a %h d %h want 1 1c000080 00a00093",
        valid_o, addr_o, rdata_o);
    end
    held = rdata_o;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b1 || rdata_o !== 32'h00A0_0093 ||
        addr_o !== 32'h1C00_0080) begin
      n_fail++;
      $display("FAIL br_hold: v %b a %h d %h was %h",
        valid_o, addr_o, rdata_o, held);
    end
  endtask

  task automatic test_compressed();
    bit ok;
    do_reset();
    mem_word[10'h040] = 32'h0001_4501;
    mem_word[10'h041] = 32'h0000_0513;
    step();
    req_i = 1'b1; ready_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h0000_0102;
    step();
    branch_i = 1'b0;
    wait_valid(12, ok);
    n_cmp++;
    if (!ok || addr_o !== 32'h102 ||
        rdata_o[15:0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL c_slot0: ok %0d a %h d %h want 102 ....0001",
        ok, addr_o, rdata_o);
    end
    wait_valid(12, ok);
    n_cmp++;
    if (!ok || addr_o !== 32'h104 ||
        rdata_o !== 32'h0000_0513) begin
      n_fail++;
      $display("FAIL c_slot1: ok %0d a %h d %h want 104 00000513",
        ok, addr_o, rdata_o);
    end
  endtask

  task automatic test_straddle();
    bit ok;
    do_reset();
    mem_word[10'h040] = 32'h0093_0000;
    mem_word[10'h041] = 32'h0000_00A0;
    step();
    req_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h0000_0102;
    step();
    branch_i = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL s_one_word: valid %b want 0", valid_o);
    end
    wait_valid(12, ok);
    n_cmp++;
    if (!ok || addr_o !== 32'h102 ||
        rdata_o !== 32'h00A0_0093) begin
      n_fail++;
      $display("FAIL s_slot: ok %0d a %h d %h want 102 00a00093",
        ok, addr_o, rdata_o);
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (addr_o !== 32'h106 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL s_next: a %h v %b want 106 1",
        addr_o, valid_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step();
    naccept = 0;
    req_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (naccept !== 2) begin
      n_fail++;
      $display("FAIL bp_rate: %0d grants in 4 cycles want 2",
        naccept);
    end
    repeat (10) step();
    @(negedge clk); #1;
    n_cmp++;
    if (naccept !== 4 || instr_req_o !== 1'b0 ||
        busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: n %0d req %b busy %b want 4 0 0",
        naccept, instr_req_o, busy_o);
    end
    step();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_cmp++;
    if (naccept !== 5 || instr_req_o !== 1'b0 ||
        addr_o !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_pulse: n %0d req %b a %h want 5 0 4",
        naccept, instr_req_o, addr_o);
    end
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    mem_word[10'h042] = 32'hDEAD_BEEF;
    mem_word[10'h080] = 32'h0000_0513;
    lat = 1;
    step();
    req_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h0000_0108;
    step();
    addr_i = 32'h0000_0200;
    @(negedge clk);
    n_cmp++;
    if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ab_inflight: req %b busy %b want 0 1",
        instr_req_o, busy_o);
    end
    step();
    branch_i = 1'b0;
    lat = 0;
    @(negedge clk);
    n_cmp++;
    if (instr_req_o !== 1'b1 ||
        instr_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL ab_refetch: req %b addr %h want 1 200",
        instr_req_o, instr_addr_o);
    end
    wait_valid(12, ok);
    n_cmp++;
    if (!ok || addr_o !== 32'h200 ||
        rdata_o !== 32'h0000_0513) begin
      n_fail++;
      $display("FAIL ab_slot: ok %0d a %h d %h want 200 00000513",
        ok, addr_o, rdata_o);
    end
  endtask

  task automatic test_pmp();
    do_reset();
    step();
    req_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h0000_0300;
    instr_err_pmp_i = 1'b1;
    step();
    branch_i = 1'b0;
    instr_err_pmp_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fetch_failed_o !== 1'b1 || instr_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pmp_set: ff %b req %b want 1 0",
        fetch_failed_o, instr_req_o);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fetch_failed_o !== 1'b1 || instr_req_o !== 1'b0 ||
        busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pmp_sticky: ff %b req %b busy %b want 1 0 0",
        fetch_failed_o, instr_req_o, busy_o);
    end
    step();
    branch_i = 1'b1; addr_i = 32'h0000_0400;
    @(negedge clk);
    n_cmp++;
    if (instr_req_o !== 1'b1 ||
        instr_addr_o !== 32'h400) begin
      n_fail++;
      $display("FAIL pmp_rebr: req %b addr %h want 1 400",
        instr_req_o, instr_addr_o);
    end
    step();
    branch_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fetch_failed_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pmp_clear: ff %b want 0", fetch_failed_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    req_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'hFFFF_FFFC;
    step();
    branch_i = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (instr_req_o !== 1'b1 ||
        instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: req %b addr %h want 1 00000000",
        instr_req_o, instr_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    lat = 2;
    step();
    req_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h0000_0100;
    step();
    branch_i = 1'b0;
    req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0 || instr_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async: busy %b req %b want 0 0",
        busy_o, instr_req_o);
    end
    step();
    rst_n = 1'b1;
    lat = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_o || busy_o) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_ignore: late rvalid seen %0d want 0",
        seen);
    end
  endtask

  initial begin
    test_reset();
    test_branch_aligned();
    test_compressed();
    test_straddle();
    test_backpressure();
    test_abort();
    test_pmp();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_fail);
    $finish;
  end

endmodule
